// File: rtl/fixedpt_accumulator.sv
// Signed fixed-point accumulator: sums a stream of product terms and presents
// a saturated n-bit result together with the term count.
//
// state | meaning
// IDLE  | waiting for the first term of a new sum
// ACCUM | adding terms until one is marked final
// DONE  | holding the saturated result until the send handshake
module fixedpt_accumulator #(
  parameter int n = 32,
  parameter int d = 16,
  parameter int g = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] recv_msg,
  input  logic         recv_last,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] send_msg,
  output logic         send_ovf,
  output logic [7:0]   send_cnt
);

  localparam int aw = n + g;
  // Largest positive value, written as its integer and fraction fields.
  localparam logic [n-1:0] sat_max = {1'b0, {(n-1-d){1'b1}}, {d{1'b1}}};
  localparam logic [n-1:0] sat_min = {1'b1, {(n-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t        state;
  logic [aw-1:0] acc;
  logic [7:0]    cnt;

  logic [aw-1:0] term_ext;
  logic          recv_fire;
  logic          send_fire;
  logic          term_final;

  assign term_ext   = {{g{recv_msg[n-1]}}, recv_msg};
  assign recv_fire  = recv_val && recv_rdy;
  assign send_fire  = send_val && send_rdy;
  // The 255th term closes the sum so the 8-bit count never wraps.
  assign term_final = recv_last || ((state == ACCUM) && (cnt == 8'd254));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      recv_rdy <= 1'b1;
      send_val <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (recv_fire) begin
            acc <= term_ext;
            cnt <= 8'd1;
            if (term_final) begin
              state    <= DONE;
              recv_rdy <= 1'b0;
              send_val <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (recv_fire) begin
            acc <= acc + term_ext;
            cnt <= cnt + 8'd1;
            if (term_final) begin
              state    <= DONE;
              recv_rdy <= 1'b0;
              send_val <= 1'b1;
            end
          end
        end
        DONE: begin
          if (send_fire) begin
            state    <= IDLE;
            recv_rdy <= 1'b1;
            send_val <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          recv_rdy <= 1'b1;
          send_val <= 1'b0;
        end
      endcase
    end
  end

  // In range when the guard bits and the result sign bit all agree.
  logic [g:0] acc_top;
  logic       in_range;

  assign acc_top  = acc[aw-1:n-1];
  assign in_range = (&acc_top) || (~|acc_top);

  assign send_msg = in_range ? acc[n-1:0] : (acc[aw-1] ? sat_min : sat_max);
  assign send_ovf = ~in_range;
  assign send_cnt = cnt;

endmodule

// File: tb/tb_fixedpt_accumulator.sv
// Directed and model-checked stimulus for fixedpt_accumulator (n=32, d=16, g=8).
module tb_fixedpt_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        recv_val;
  logic        recv_rdy;
  logic [31:0] recv_msg;
  logic        recv_last;
  logic        send_val;
  logic        send_rdy;
  logic [31:0] send_msg;
  logic        send_ovf;
  logic [7:0]  send_cnt;

  int total = 0;
  int bad   = 0;

  fixedpt_accumulator #(.n(32), .d(16), .g(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .recv_msg (recv_msg),
    .recv_last(recv_last),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .send_msg (send_msg),
    .send_ovf (send_ovf),
    .send_cnt (send_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_term(input logic [31:0] m, input logic l, output int waited);
    logic was_rdy;
    int   k;
    k = 0;
    recv_val  = 1'b1;
    recv_msg  = m;
    recv_last = l;
    do begin
      was_rdy = recv_rdy;
      tick();
      k++;
    end while (!was_rdy && k < 20);
    chk("recv_hs", 32'(was_rdy), 32'd1);
    waited    = k;
    recv_val  = 1'b0;
    recv_last = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] m, input logic o, input logic [7:0] c);
    chk({tag, "_val"}, 32'(send_val), 32'd1);
    chk({tag, "_msg"}, send_msg, m);
    chk({tag, "_ovf"}, 32'(send_ovf), 32'(o));
    chk({tag, "_cnt"}, 32'(send_cnt), 32'(c));
  endtask

  task automatic take();
    send_rdy = 1'b1;
    tick();
    send_rdy = 1'b0;
    chk("take_val", 32'(send_val), 32'd0);
    chk("take_rdy", 32'(recv_rdy), 32'd1);
  endtask

  initial begin
    int          w;
    longint      sum;
    int          nterm;
    logic [31:0] term;
    logic [31:0] exp_msg;
    logic        exp_ovf;

    reset = 1'b1; recv_val = 1'b0; recv_msg = '0; recv_last = 1'b0; send_rdy = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_rdy", 32'(recv_rdy), 32'd1);
    chk("rst_val", 32'(send_val), 32'd0);
    chk("rst_msg", send_msg, 32'h0);
    chk("rst_ovf", 32'(send_ovf), 32'd0);
    chk("rst_cnt", 32'(send_cnt), 32'd0);

    // 1.5 + 2.5 - 1.0 back-to-back; result visible one cycle after the last term
    send_term(32'h0001_8000, 1'b0, w);
    send_term(32'h0002_8000, 1'b0, w);
    chk("b2b_not_done", 32'(send_val), 32'd0);
    send_term(32'hFFFF_0000, 1'b1, w);
    check_out("sum3", 32'h0003_0000, 1'b0, 8'd3);
    take();

    // single most-negative term, held in DONE with send_rdy low
    send_term(32'h8000_0000, 1'b1, w);
    for (int i = 0; i < 5; i++) begin
      chk("hold_rdy", 32'(recv_rdy), 32'd0);
      check_out("hold", 32'h8000_0000, 1'b0, 8'd1);
      tick();
    end
    // a term offered during the send handshake must not be taken that cycle
    recv_val = 1'b1; recv_msg = 32'h0005_0000; recv_last = 1'b1; send_rdy = 1'b1;
    tick();
    send_rdy = 1'b0;
    chk("nobyp_val", 32'(send_val), 32'd0);
    chk("nobyp_rdy", 32'(recv_rdy), 32'd1);
    tick();
    recv_val = 1'b0; recv_last = 1'b0;
    check_out("nobyp", 32'h0005_0000, 1'b0, 8'd1);
    take();

    // positive and negative saturation
    send_term(32'h7FFF_0000, 1'b0, w);
    send_term(32'h0002_0000, 1'b1, w);
    check_out("satpos", 32'h7FFF_FFFF, 1'b1, 8'd2);
    take();
    send_term(32'h8000_0000, 1'b0, w);
    send_term(32'h8000_0000, 1'b1, w);
    check_out("satneg", 32'h8000_0000, 1'b1, 8'd2);
    take();

    // 255 terms without recv_last close the sum on their own
    for (int i = 0; i < 255; i++) begin
      send_term(32'h0001_0000, 1'b0, w);
      if (i == 253) chk("cnt254_val", 32'(send_val), 32'd0);
    end
    check_out("max255", 32'h00FF_0000, 1'b0, 8'd255);
    send_rdy = 1'b1;
    send_term(32'h0002_0000, 1'b1, w);
    send_rdy = 1'b0;
    chk("t256_wait", 32'(w), 32'd2);
    check_out("t256", 32'h0002_0000, 1'b0, 8'd1);
    take();

    // reset mid-sum and in DONE discards the partial sum
    send_term(32'h0001_0000, 1'b0, w);
    send_term(32'h0001_0000, 1'b0, w);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_val", 32'(send_val), 32'd0);
    chk("rstmid_rdy", 32'(recv_rdy), 32'd1);
    chk("rstmid_cnt", 32'(send_cnt), 32'd0);
    send_term(32'h0003_0000, 1'b0, w);
    send_term(32'h0004_0000, 1'b1, w);
    check_out("after_rst", 32'h0007_0000, 1'b0, 8'd2);
    reset = 1'b1; send_rdy = 1'b1;
    tick();
    reset = 1'b0; send_rdy = 1'b0;
    chk("rstdone_val", 32'(send_val), 32'd0);
    chk("rstdone_msg", send_msg, 32'h0);
    send_term(32'h0005_0000, 1'b1, w);
    check_out("after_rst2", 32'h0005_0000, 1'b0, 8'd1);
    take();

    // random sums with idle gaps carrying stray recv_last pulses
    for (int s = 0; s < 1000; s++) begin
      nterm = $urandom_range(1, 4);
      sum = 0;
      for (int i = 0; i < nterm; i++) begin
        for (int gap = $urandom_range(0, 2); gap > 0; gap--) begin
          recv_val = 1'b0; recv_last = 1'($urandom_range(0, 1)); recv_msg = $urandom;
          tick();
        end
        term = $urandom;
        sum += longint'(signed'(term));
        send_term(term, (i == nterm - 1), w);
      end
      if (sum > 64'sd2147483647) begin
        exp_msg = 32'h7FFF_FFFF; exp_ovf = 1'b1;
      end else if (sum < -64'sd2147483648) begin
        exp_msg = 32'h8000_0000; exp_ovf = 1'b1;
      end else begin
        exp_msg = sum[31:0]; exp_ovf = 1'b0;
      end
      check_out("rand", exp_msg, exp_ovf, 8'(nterm));
      take();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fixedpt_accumulator.md
FIXEDPT_ACCUMULATOR -- requirements
Module: fixedpt_accumulator

Interface
REQ-001 Parameter n SHALL be, default 32, operand/result bit width (signed two's complement fixed point).
REQ-002 Parameter d SHALL be, default 16, number of fractional bits; the binary point SHALL be preserved unchanged through the block.
REQ-003 Parameter g SHALL be, default 8, accumulator guard bits; internal accumulator width SHALL be n+g.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 recv_val  input  1  upstream term valid (driven by the fixed-point multiplier's send_val).
REQ-007 recv_rdy  output  1  block can accept a term this cycle.
REQ-008 recv_msg  input  n  signed fixed-point product term.
REQ-009 recv_last  input  1  marks the final term of the current sum; sampled only on a recv handshake.
REQ-010 send_val  output  1  result valid.
REQ-011 send_rdy  input  1  downstream can accept the result.
REQ-012 send_msg  output  n  saturated signed fixed-point sum.
REQ-013 send_ovf  output  1  send_msg was saturated.
REQ-014 send_cnt  output  8  number of terms in the sum (1..255).

Function
REQ-015 A recv handshake SHALL occur when recv_val && recv_rdy are high at a rising edge; a send handshake when send_val && send_rdy are high.
REQ-016 The FSM SHALL have states IDLE, ACCUM, DONE.
REQ-017 IDLE: recv_rdy=1, send_val=0; on recv handshake, acc <= sign_ext(recv_msg), cnt <= 1, next state ACCUM, or DONE if the term is final.
REQ-018 ACCUM: recv_rdy=1, send_val=0; on recv handshake, acc <= acc + sign_ext(recv_msg), cnt <= cnt+1; next state DONE if the term is final, else ACCUM; no handshake holds all state.
REQ-019 A term SHALL be final when recv_last=1 or when it is the 255th term (cnt becomes 255); recv_last SHALL be ignored when recv_val=0.
REQ-020 DONE: recv_rdy=0, send_val=1; send_msg, send_ovf, send_cnt SHALL be stable until the send handshake, which SHALL return the FSM to IDLE.
REQ-021 DONE SHALL NOT accept a new term in the handshake cycle (no bypass); the next term is accepted no earlier than the following cycle in IDLE.
REQ-022 Sign extension SHALL replicate recv_msg[n-1] into the g upper bits; addition SHALL be n+g-bit two's complement, which cannot wrap for <=255 terms.
REQ-023 send_msg SHALL equal acc[n-1:0] when acc lies in [-2^(n-1), 2^(n-1)-1], else 2^(n-1)-1 (positive) or -2^(n-1) (negative) with send_ovf=1.
REQ-024 Throughput SHALL be one term per cycle; latency from the final recv handshake to send_val=1 SHALL be exactly 1 cycle.
REQ-025 send_msg, send_ovf, send_cnt SHALL be combinational functions of acc/cnt registers only, never of recv_msg.
REQ-026 Outputs other than send_val/recv_rdy SHALL be don't-care outside DONE but SHALL NOT be X after reset.

Reset
REQ-027 Reset SHALL force state=IDLE, acc=0, cnt=0, hence recv_rdy=1, send_val=0, send_msg=0, send_ovf=0, send_cnt=0 on the following cycle.
REQ-028 Reset SHALL take priority over any handshake in the same cycle, including mid-ACCUM or in DONE; the partial sum SHALL be discarded.

Verification
REQ-029 Terms 0x00018000 (1.5), 0x00028000 (2.5), 0xFFFF0000 (-1.0, last) back-to-back -> one cycle later send_val=1, send_msg=0x00030000, send_cnt=3, send_ovf=0.
REQ-030 Single term 0x80000000 with recv_last=1 -> send_msg=0x80000000, send_cnt=1, send_ovf=0; recv_rdy=0 while send_rdy held low 5 cycles, outputs stable.
REQ-031 Terms 0x7FFF0000 then 0x00020000 (last) -> send_msg=0x7FFFFFFF, send_ovf=1; terms 0x80000000 twice -> send_msg=0x80000000, send_ovf=1.
REQ-032 255 terms of 0x00010000, recv_last=0 throughout -> DONE after 255th, send_msg=0x00FF0000, send_cnt=255; 256th term waits for IDLE and starts a new sum.
REQ-033 recv_val toggled randomly with recv_last pulses while recv_val=0 -> those pulses ignored; sums match reference model over 1000 random sequences.
REQ-034 Reset asserted after 2 of 4 terms, and again in DONE -> next cycle IDLE, send_val=0; subsequent sum excludes discarded terms.
